// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared widths, duty limits and lane unpacking for the LED PWM driver
package led_pwm_pkg;

    localparam int c_duty_bits = 8;
    localparam logic [c_duty_bits-1:0] c_duty_max = 8'd254;
    // Upper bound on the number of channels a driver can pack into one vector
    localparam int c_max_lanes = 64;
    localparam int c_lane_vec_bits = c_duty_bits * c_max_lanes;

    typedef logic [c_duty_bits-1:0] duty_t;

    // LED k lives at [8k+7:8k] of a packed value vector
    function automatic duty_t get_lane(input logic [c_lane_vec_bits-1:0] vec, input int unsigned k);
        return vec[c_duty_bits*k +: c_duty_bits];
    endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// clock_enable_divider: one-cycle clock enable every par_ce_divisor clocks
//   i_clk_mhz  clock
//   i_rst_mhz  synchronous active-high reset
//   o_ce_mhz   registered enable pulse; first pulse consumed par_ce_divisor edges after reset release
module clock_enable_divider #(
    parameter int par_ce_divisor = 2
) (
    input  logic i_clk_mhz,
    input  logic i_rst_mhz,
    output logic o_ce_mhz
);

    localparam int c_cnt_bits = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
    localparam logic [c_cnt_bits-1:0] c_last = c_cnt_bits'(par_ce_divisor - 1);

    logic [c_cnt_bits-1:0] s_cnt_q, s_cnt_d;
    logic s_ce_q, s_ce_d;

    always_comb begin
        s_ce_d  = (s_cnt_q == c_last);
        s_cnt_d = s_ce_d ? '0 : s_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk_mhz) begin
        if (i_rst_mhz) begin
            s_cnt_q <= '0;
            s_ce_q  <= 1'b0;
        end else begin
            s_cnt_q <= s_cnt_d;
            s_ce_q  <= s_ce_d;
        end
    end

    assign o_ce_mhz = s_ce_q;

endmodule

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one PWM lane with a period-aligned shadow of its duty value
//   i_clk     clock
//   i_srst_n  synchronous active-low reset
//   i_duty    shared duty counter
//   i_load    period-start strobe; shadow captures i_value
//   i_value   requested duty for this lane
//   o_pwm     registered PWM output
module led_pwm_channel
    import led_pwm_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_srst_n,
    input  duty_t i_duty,
    input  logic  i_load,
    input  duty_t i_value,
    output logic  o_pwm
);

    duty_t s_shadow_q, s_shadow_d;
    logic s_pwm_q, s_pwm_d;

    always_comb begin
        s_shadow_d = i_load ? i_value : s_shadow_q;
        s_pwm_d    = (i_duty < s_shadow_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            s_shadow_q <= '0;
            s_pwm_q    <= 1'b0;
        end else begin
            s_shadow_q <= s_shadow_d;
            s_pwm_q    <= s_pwm_d;
        end
    end

    assign o_pwm = s_pwm_q;

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: PWM drive for N RGB LEDs and M basic LEDs from 8-bit palette values
//   i_clk, i_srst_n                 clock, synchronous active-low reset
//   i_color_led_{red,green,blue}_value  8*N duty values, LED k at [8k+7:8k]
//   i_basic_led_lumin_value         8*M duty values, same packing
//   o_color_led_{red,green,blue}    N PWM outputs, bit k = LED k
//   o_basic_led                     M PWM outputs
//   o_period_strobe                 one-cycle pulse after each period start
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int parm_color_led_count = 4,
    parameter int parm_basic_led_count = 4,
    parameter int parm_FCLK            = 40_000_000,
    parameter int parm_pwm_freq_hz     = 5_000
) (
    input  logic                              i_clk,
    input  logic                              i_srst_n,
    input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
    input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
    input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
    output logic [parm_color_led_count-1:0]   o_color_led_red,
    output logic [parm_color_led_count-1:0]   o_color_led_green,
    output logic [parm_color_led_count-1:0]   o_color_led_blue,
    output logic [parm_basic_led_count-1:0]   o_basic_led,
    output logic                              o_period_strobe
);

    localparam int c_step_divisor = parm_FCLK / (parm_pwm_freq_hz * 255);
    localparam int c_n            = parm_color_led_count;
    localparam int c_m            = parm_basic_led_count;
    localparam int c_lanes        = 3 * c_n + c_m;
    localparam int c_vec_bits     = c_duty_bits * c_lanes;

    logic s_step_ce;
    logic s_period_start;
    duty_t s_duty_q, s_duty_d;
    logic s_strobe_q, s_strobe_d;
    logic [c_vec_bits-1:0] s_values;
    logic [c_lane_vec_bits-1:0] s_values_pad;
    logic [c_lanes-1:0] s_pwm;

    clock_enable_divider #(
        .par_ce_divisor(c_step_divisor)
    ) u_step_div (
        .i_clk_mhz(i_clk),
        .i_rst_mhz(~i_srst_n),
        .o_ce_mhz (s_step_ce)
    );

    // Duty counter runs 0..254 so that 255 is never reached and a value of 255 stays high
    always_comb begin
        s_period_start = s_step_ce && (s_duty_q == c_duty_max);
        s_duty_d       = s_period_start ? '0 : (s_step_ce ? s_duty_q + 1'b1 : s_duty_q);
        s_strobe_d     = s_period_start;
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            s_duty_q   <= '0;
            s_strobe_q <= 1'b0;
        end else begin
            s_duty_q   <= s_duty_d;
            s_strobe_q <= s_strobe_d;
        end
    end

    // Lanes ordered red, green, blue, basic from the LSB up
    assign s_values     = {i_basic_led_lumin_value, i_color_led_blue_value,
                           i_color_led_green_value, i_color_led_red_value};
    assign s_values_pad = c_lane_vec_bits'(s_values);

    for (genvar g = 0; g < c_lanes; g++) begin : g_lane
        led_pwm_channel u_ch (
            .i_clk   (i_clk),
            .i_srst_n(i_srst_n),
            .i_duty  (s_duty_q),
            .i_load  (s_period_start),
            .i_value (get_lane(s_values_pad, g)),
            .o_pwm   (s_pwm[g])
        );
    end

    assign o_color_led_red   = s_pwm[c_n-1:0];
    assign o_color_led_green = s_pwm[2*c_n-1:c_n];
    assign o_color_led_blue  = s_pwm[3*c_n-1:2*c_n];
    assign o_basic_led       = s_pwm[c_lanes-1:3*c_n];
    assign o_period_strobe   = s_strobe_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: directed checks of period timing, pulse widths, shadowing and reset
module tb_led_pwm_driver;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int FPWM = 5_000;
    localparam int FCLK = 2 * 255 * FPWM;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    logic [8*N-1:0] red_v = '0, green_v = '0, blue_v = '0;
    logic [8*M-1:0] basic_v = '0;
    logic [N-1:0] red, green, blue;
    logic [M-1:0] basic;
    logic strobe;
    logic [15:0] pwm;

    int n_checks = 0;
    int n_pass = 0;
    int k;
    int hi[16];
    int first[16];
    int last[16];
    int cyc, lit;
    int st_idx[3];
    int n_st;

    always #5 clk = ~clk;

    assign pwm = {basic, blue, green, red};

    led_pwm_driver #(
        .parm_color_led_count(N),
        .parm_basic_led_count(M),
        .parm_FCLK           (FCLK),
        .parm_pwm_freq_hz    (FPWM)
    ) dut (
        .i_clk                  (clk),
        .i_srst_n               (srst_n),
        .i_color_led_red_value  (red_v),
        .i_color_led_green_value(green_v),
        .i_color_led_blue_value (blue_v),
        .i_basic_led_lumin_value(basic_v),
        .o_color_led_red        (red),
        .o_color_led_green      (green),
        .o_color_led_blue       (blue),
        .o_basic_led            (basic),
        .o_period_strobe        (strobe)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_stats();
        k = 0;
        for (int b = 0; b < 16; b++) begin
            hi[b] = 0;
            first[b] = 0;
            last[b] = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k++;
            for (int b = 0; b < 16; b++) begin
                if (pwm[b]) begin
                    hi[b]++;
                    if (first[b] == 0) first[b] = k;
                    last[b] = k;
                end
            end
        end
    endtask

    function automatic int others_hi(input int keep);
        int s = 0;
        for (int b = 0; b < 16; b++) if (b != keep) s += hi[b];
        return s;
    endfunction

    task automatic wait_strobe(output int c, output int l);
        c = 0;
        l = 0;
        do begin
            @(negedge clk);
            c++;
            if (pwm != 0) l++;
        end while (!strobe && c < 1200);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_strobe", int'(strobe), 0);

        // Release with all values 0 and observe three periods
        srst_n = 1'b1;
        lit = 0;
        n_st = 0;
        for (int i = 1; i <= 1540; i++) begin
            @(negedge clk);
            if (pwm != 0) lit++;
            if (strobe) begin
                if (n_st < 3) st_idx[n_st] = i;
                n_st++;
            end
        end
        chk("zero_dark_cycles", lit, 0);
        chk("zero_strobe_count", n_st, 3);
        chk("first_strobe", st_idx[0], 511);
        chk("second_strobe", st_idx[1], 1021);
        chk("third_strobe", st_idx[2], 1531);

        // Red LED0 = 255: loads at the next period start
        red_v = 32'h0000_00FF;
        wait_strobe(cyc, lit);
        chk("red255_wait", cyc, 501);
        chk("red255_dark_before", lit, 0);
        chk("red255_latency", int'(red), 0);
        clear_stats();
        run_cycles(510);
        chk("red255_width", hi[0], 510);
        chk("red255_rise", first[0], 1);
        chk("red255_others", others_hi(0), 0);
        chk("period_len", int'(strobe), 1);

        // Basic LED2 = 128; the current period still shows the old red value
        red_v = '0;
        basic_v = 32'h0080_0000;
        clear_stats();
        run_cycles(510);
        chk("red_held", hi[0], 510);
        chk("basic_not_early", hi[14], 0);
        clear_stats();
        run_cycles(510);
        chk("basic128_width", hi[14], 256);
        chk("basic128_rise", first[14], 1);
        chk("basic128_fall", last[14], 256);
        chk("basic128_others", others_hi(14), 0);
        chk("basic128_strobe", int'(strobe), 1);

        // Green LED3 10 -> 200 mid-period
        basic_v = '0;
        green_v = 32'h0A00_0000;
        clear_stats();
        run_cycles(510);
        chk("green_not_early", hi[7], 0);
        clear_stats();
        run_cycles(255);
        green_v = 32'hC800_0000;
        run_cycles(255);
        chk("green10_width", hi[7], 20);
        chk("green10_rise", first[7], 1);
        chk("green10_strobe", int'(strobe), 1);
        clear_stats();
        run_cycles(510);
        chk("green200_width", hi[7], 400);
        chk("green200_fall", last[7], 400);
        chk("green200_others", others_hi(7), 0);

        // Blue LED1 = 100, then a one-cycle reset in the middle of its pulse
        green_v = '0;
        blue_v = 32'h0000_6400;
        clear_stats();
        run_cycles(510);
        clear_stats();
        run_cycles(50);
        chk("blue_pre_reset", hi[9], 50);
        srst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_pwm", int'(pwm), 0);
        chk("reset_mid_strobe", int'(strobe), 0);
        srst_n = 1'b1;
        wait_strobe(cyc, lit);
        chk("rerelease_strobe", cyc, 511);
        chk("rerelease_dark", lit, 0);
        clear_stats();
        run_cycles(510);
        chk("blue100_width", hi[9], 200);
        chk("blue100_rise", first[9], 1);
        chk("blue100_fall", last[9], 200);

        // Distinct red values per lane confirm packing
        blue_v = '0;
        red_v = 32'h0403_0201;
        clear_stats();
        run_cycles(510);
        clear_stats();
        run_cycles(510);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("red_lane%0d_width", b), hi[b], 2 * (b + 1));
            chk($sformatf("red_lane%0d_rise", b), first[b], 1);
        end
        chk("red_lanes_others", hi[4] + hi[5] + hi[6] + hi[7] + hi[8] + hi[9] + hi[10]
            + hi[11] + hi[12] + hi[13] + hi[14] + hi[15], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Converts the per-LED 8-bit palette values produced by the LED palette pulser into PWM drive for four RGB color LEDs and four basic LEDs. It sits directly downstream of the pulser and directly upstream of the board LED pins. A shared prescaler and an 8-bit duty counter generate one PWM period. Each channel compares the counter against a shadow copy of its palette value. Shadows reload only at period boundaries, so a value change never produces a truncated or glitched pulse.

## Interface
Reset is synchronous, active-low; single clock domain.
- parm_color_led_count, 4, number of RGB LEDs (N)
- parm_basic_led_count, 4, number of single-color LEDs (M)
- parm_FCLK, 40_000_000, i_clk frequency in Hz
- parm_pwm_freq_hz, 5_000, target PWM period rate
- c_step_divisor, parm_FCLK / (parm_pwm_freq_hz * 255), clocks per duty step (D); must be >= 1
- i_clk  in  1  system clock
- i_srst_n  in  1  synchronous active-low reset
- i_color_led_red_value  in  8*N  red duty per LED; LED k at [8k+7:8k]
- i_color_led_green_value  in  8*N  green duty, same packing
- i_color_led_blue_value  in  8*N  blue duty, same packing
- i_basic_led_lumin_value  in  8*M  basic LED duty, same packing
- o_color_led_red  out  N  red PWM, bit k = LED k
- o_color_led_green  out  N  green PWM
- o_color_led_blue  out  N  blue PWM
- o_basic_led  out  M  basic LED PWM
- o_period_strobe  out  1  one-cycle pulse marking a new period

## Operation
- Prescaler s_presc counts from 0 to D-1 and wraps. s_step_ce = (s_presc == D-1).
- Duty counter s_duty is 8 bits. On s_step_ce it increments 0..254, then wraps 254 -> 0. One period is 255*D clocks.
- The period-start cycle is s_step_ce & (s_duty == 254). On its edge:
  - all shadows <= inputs;
  - s_duty <= 0;
  - o_period_strobe <= 1.
- Channel output is registered: out <= (s_duty < shadow), an unsigned 8-bit compare.
  - Value 0: never high.
  - Value 255: always high.
  - Value v: high for exactly v*D clocks per period.
- Input changes at any other time are ignored until the next period start.
- During reset (i_srst_n = 0):
  - s_presc, s_duty, all shadows, all PWM outputs and o_period_strobe are cleared to 0;
  - this applies from the edge that samples reset low, including mid-period.

## Timing
- Reset release: the first s_step_ce occurs D cycles after the first edge with i_srst_n = 1. The first period-start occurs 255*D cycles after release.
- Outputs stay 0 throughout the first period, because the shadows are 0.
- Edge E0 closes a period-start cycle:
  - shadows, s_duty = 0 and o_period_strobe = 1 are visible after E0;
  - after E1, outputs reflect (0 < shadow) and o_period_strobe returns to 0.
  - Strobe-to-output latency is 1 cycle.
- A falling edge occurs at E1 + v*D for 0 < v < 255.
- No combinational path from any input to any output.

## Structure
- Package led_pwm_pkg:
  - c_duty_bits = 8;
  - c_duty_max = 254;
  - function packing/unpacking LED k from the 8*N vectors.
- Reuse clock_enable_divider for s_step_ce, with par_ce_divisor = c_step_divisor and i_rst_mhz = ~i_srst_n.
- Sub-module led_pwm_channel holds one shadow register and the registered compare, with inputs s_duty and load strobe. It is instantiated 3*N + M times via generate.

## Test plan
Run with parm_FCLK = 2*255*parm_pwm_freq_hz, giving D = 2 and a period of 510 clocks.
- All values 0, run 3 periods -> all PWM outputs 0 every cycle; o_period_strobe pulses every 510 cycles, the first at release + 511.
- Red LED0 = 255, others 0 -> o_color_led_red[0] high continuously from 1 cycle after the first strobe; all other bits stay 0.
- Basic LED2 = 128 -> high 256 clocks then low 254 clocks each period, rising 1 cycle after each strobe.
- Green LED3 changed from 10 to 200 at mid-period -> current period keeps a 20-clock pulse; the next period gives a 400-clock pulse.
- i_srst_n driven low for 1 cycle mid-pulse with blue LED1 = 100 -> output 0 on the next cycle, s_duty = 0, shadows 0; output dark until the first strobe at release + 511, then a 200-clock pulse.
- Distinct values 1, 2, 3, 4 in LED0..3 red lanes -> pulse widths 2, 4, 6, 8 clocks on bits 0..3, confirming lane packing.
